// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//
// Writeback stage of the LC2K pipeline. Picks one of NUM_SRC result sources
// (0 = memResult, 1 = aluResult, 2 = pcPlusOne, ...), registers the chosen
// value together with its destination register, and presents a register-file
// write port. A two-entry skid buffer (head H + skid S) lets in_ready be a
// function of registered state only.
//
// Handshake: a record transfers on a side when that side's valid and ready
// are both high at a rising clock edge. Valid never waits for ready, and
// in_ready never looks at in_valid.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        upstream handshake
//   in_src                     packed sources, source k at [k*DATA_W +: DATA_W]
//   in_sel                     source select
//   in_dest, in_wr_en          destination register and write-enable of record
//   flush                      discard every held record
//   out_ready / out_valid      downstream handshake on the head record
//   out_we, out_dest, out_data register-file write port
//   fwd_valid/dest/data        forwarding tap (mirrors the write port)
//   retire_cnt                 count of consumed records that wrote a register
//   sel_err                    sticky flag: a record arrived with a bad in_sel
// ---------------------------------------------------------------------------
module wb_select_stage #(
  parameter int DATA_W      = 32,
  parameter int NUM_SRC     = 3,
  parameter int SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  parameter int REG_AW      = 3,
  parameter int ZERO_REG_RO = 0,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [REG_AW-1:0]         in_dest,
  input  logic                      in_wr_en,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_we,
  output logic [REG_AW-1:0]         out_dest,
  output logic [DATA_W-1:0]         out_data,
  output logic                      fwd_valid,
  output logic [REG_AW-1:0]         fwd_dest,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic                      sel_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dest;
    logic              wr_en;
  } rec_t;

  rec_t             h_q, h_d;
  rec_t             s_q, s_d;
  logic             h_valid_q, h_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             sel_err_q, sel_err_d;

  logic [DATA_W-1:0] sel_data;
  logic              sel_bad;
  rec_t              in_rec;
  logic              accept;
  logic              consume;
  logic              head_we;

  // Source mux. An out-of-range select leaves sel_data at zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (32'(in_sel) == k) sel_data = in_src[k*DATA_W +: DATA_W];
    end
  end

  assign sel_bad = (32'(in_sel) >= NUM_SRC);

  // A bad select is turned into a harmless non-writing record.
  always_comb begin
    in_rec       = '0;
    in_rec.data  = sel_data;
    in_rec.dest  = in_dest;
    in_rec.wr_en = in_wr_en && !sel_bad;
  end

  assign in_ready = !s_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign consume  = h_valid_q && out_ready;

  // Writes to r0 are dropped when r0 is hard-wired to zero.
  assign head_we = h_valid_q && h_q.wr_en &&
                   !((ZERO_REG_RO != 0) && (h_q.dest == '0));

  // Next-state for the two-entry buffer, counter and error flag.
  always_comb begin
    h_d          = h_q;
    s_d          = s_q;
    h_valid_d    = h_valid_q;
    s_valid_d    = s_valid_q;
    retire_cnt_d = retire_cnt_q;
    sel_err_d    = sel_err_q;

    if (consume && head_we) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (accept && sel_bad)  sel_err_d    = 1'b1;

    if (flush) begin
      // Everything held or arriving this cycle is discarded.
      h_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!h_valid_q) begin
      if (accept) begin
        h_d       = in_rec;
        h_valid_d = 1'b1;
      end
    end else if (consume) begin
      if (s_valid_q) begin
        // in_ready was low, so nothing new arrives this cycle.
        h_d       = s_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        h_d = in_rec;
      end else begin
        h_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_rec;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q          <= '0;
      s_q          <= '0;
      h_valid_q    <= 1'b0;
      s_valid_q    <= 1'b0;
      retire_cnt_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      h_q          <= h_d;
      s_q          <= s_d;
      h_valid_q    <= h_valid_d;
      s_valid_q    <= s_valid_d;
      retire_cnt_q <= retire_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign out_valid  = h_valid_q;
  assign out_we     = head_we;
  assign out_dest   = h_q.dest;
  assign out_data   = h_q.data;
  assign fwd_valid  = head_we;
  assign fwd_dest   = h_q.dest;
  assign fwd_data   = h_q.data;
  assign retire_cnt = retire_cnt_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int SW = 2;
  localparam int EW = DW + AW + 2;  // {data, dest, we (r0 writable), we (r0 read-only)}

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [3*DW-1:0] in_src;
  logic [SW-1:0] in_sel;
  logic [AW-1:0] in_dest;
  logic          in_wr_en;
  logic          flush;
  logic          out_ready;

  // dut0: ZERO_REG_RO=0, CNT_W=16
  logic          in_ready0, out_valid0, out_we0, fwd_valid0, sel_err0;
  logic [AW-1:0] out_dest0, fwd_dest0;
  logic [DW-1:0] out_data0, fwd_data0;
  logic [15:0]   retire_cnt0;
  // dut1: ZERO_REG_RO=1, CNT_W=2
  logic          in_ready1, out_valid1, out_we1, fwd_valid1, sel_err1;
  logic [AW-1:0] out_dest1, fwd_dest1;
  logic [DW-1:0] out_data1, fwd_data1;
  logic [1:0]    retire_cnt1;

  wb_select_stage #(.ZERO_REG_RO(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_src(in_src), .in_sel(in_sel), .in_dest(in_dest), .in_wr_en(in_wr_en),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid0), .out_we(out_we0),
    .out_dest(out_dest0), .out_data(out_data0), .fwd_valid(fwd_valid0),
    .fwd_dest(fwd_dest0), .fwd_data(fwd_data0), .retire_cnt(retire_cnt0),
    .sel_err(sel_err0)
  );

  wb_select_stage #(.ZERO_REG_RO(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_src(in_src), .in_sel(in_sel), .in_dest(in_dest), .in_wr_en(in_wr_en),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid1), .out_we(out_we1),
    .out_dest(out_dest1), .out_data(out_data1), .fwd_valid(fwd_valid1),
    .fwd_dest(fwd_dest1), .fwd_data(fwd_data1), .retire_cnt(retire_cnt1),
    .sel_err(sel_err1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_cnt0;
  logic [1:0]    exp_cnt1;
  int            n_checks;
  int            n_errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid0 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_data0), 64'hdead_0000);
      end else begin
        logic [EW-1:0] e;
        logic [DW-1:0] ed;
        logic [AW-1:0] ea;
        logic          ew0, ew1;
        e = exp_q.pop_front();
        {ed, ea, ew0, ew1} = e;
        check("out_data",   64'(out_data0),  64'(ed));
        check("out_dest",   64'(out_dest0),  64'(ea));
        check("out_we",     64'(out_we0),    64'(ew0));
        check("fwd_valid",  64'(fwd_valid0), 64'(ew0));
        check("fwd_dest",   64'(fwd_dest0),  64'(ea));
        check("fwd_data",   64'(fwd_data0),  64'(ed));
        check("out_data_z", 64'(out_data1),  64'(ed));
        check("out_we_z",   64'(out_we1),    64'(ew1));
        check("fwd_valid_z", 64'(fwd_valid1), 64'(ew1));
        if (ew0) exp_cnt0 = exp_cnt0 + 16'd1;
        if (ew1) exp_cnt1 = exp_cnt1 + 2'd1;
      end
    end
  end

  // ---------------- driver ----------------
  // Caller must be just after a rising edge. Holds the record until accepted,
  // pushes the expected result at the accept, returns just after that edge.
  task automatic send(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                      input logic [DW-1:0] s2, input int sel, input int dest,
                      input logic we, input bit chk_lat);
    logic [DW-1:0] ed;
    logic          bad, ew0, ew1;
    int            waited;
    bad = (sel >= 3);
    ed  = bad ? '0 : (sel == 0) ? s0 : (sel == 1) ? s1 : s2;
    ew0 = we && !bad;
    ew1 = ew0 && (dest != 0);
    in_valid = 1'b1;
    in_src   = {s2, s1, s0};
    in_sel   = sel[SW-1:0];
    in_dest  = dest[AW-1:0];
    in_wr_en = we;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) begin
        exp_q.push_back({ed, dest[AW-1:0], ew0, ew1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chk_lat) begin
          check("lat_valid", 64'(out_valid0), 64'd1);
          check("lat_data",  64'(out_data0),  64'(ed));
        end
        return;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 20) begin
        check("send_timeout", 64'(in_ready0), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready",  64'(in_ready0),   64'd0);
    check("rst_out_valid", 64'(out_valid0),  64'd0);
    check("rst_out_we",    64'(out_we0),     64'd0);
    check("rst_out_dest",  64'(out_dest0),   64'd0);
    check("rst_out_data",  64'(out_data0),   64'd0);
    check("rst_fwd_valid", 64'(fwd_valid0),  64'd0);
    check("rst_fwd_dest",  64'(fwd_dest0),   64'd0);
    check("rst_fwd_data",  64'(fwd_data0),   64'd0);
    check("rst_retire",    64'(retire_cnt0), 64'd0);
    check("rst_sel_err",   64'(sel_err0),    64'd0);
    check("rst_retire_z",  64'(retire_cnt1), 64'd0);
    check("rst_sel_err_z", 64'(sel_err1),    64'd0);
    check("rst_valid_z",   64'(out_valid1),  64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    reset = 1'b1; in_valid = 1'b0; in_src = '0; in_sel = '0;
    in_dest = '0; in_wr_en = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Reset values, then in_ready comes up the cycle after reset drops.
    idle(2);
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready0), 64'd1);
    @(posedge clk); #1;

    // Stream three records, one per cycle, each visible one cycle after accept.
    out_ready = 1'b1;
    send(32'h11, 32'h22, 32'h33, 0, 1, 1'b1, 1'b1);
    send(32'h11, 32'h22, 32'h33, 1, 2, 1'b1, 1'b1);
    send(32'h11, 32'h22, 32'h33, 2, 3, 1'b1, 1'b1);
    idle(2);
    check("retire_after_stream", 64'(retire_cnt0), 64'd3);
    check("retire_after_stream_z", 64'(retire_cnt1), 64'd3);

    // Backpressure: two absorbed, third stalls until the skid drains.
    out_ready = 1'b0;
    send(32'hA0, 32'hA1, 32'hA2, 1, 4, 1'b1, 1'b0);
    send(32'hB0, 32'hB1, 32'hB2, 0, 5, 1'b1, 1'b0);
    fork
      send(32'hC0, 32'hC1, 32'hC2, 2, 6, 1'b1, 1'b0);
      begin
        repeat (2) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready0), 64'd0);
          check("bp_hold_valid", 64'(out_valid0), 64'd1);
          check("bp_hold_data", 64'(out_data0), 64'hA1);
          check("bp_hold_dest", 64'(out_dest0), 64'd4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(3);
    check("retire_after_bp", 64'(retire_cnt0), 64'(exp_cnt0));

    // Write to r0: only the read-only-r0 instance suppresses the strobe.
    send(32'h0, 32'h5A5A, 32'h0, 1, 0, 1'b1, 1'b1);
    idle(2);
    check("retire_r0", 64'(retire_cnt0), 64'(exp_cnt0));
    check("retire_r0_z", 64'(retire_cnt1), 64'(exp_cnt1));

    // Out-of-range select: zero data, no write, sticky error.
    send(32'h1, 32'h2, 32'h3, 3, 4, 1'b1, 1'b1);
    check("sel_err_set", 64'(sel_err0), 64'd1);
    send(32'h7, 32'h8, 32'h9, 2, 7, 1'b1, 1'b1);
    idle(2);
    check("sel_err_sticky", 64'(sel_err0), 64'd1);
    check("sel_err_sticky_z", 64'(sel_err1), 64'd1);

    // Flush with H and S full and a new record arriving.
    out_ready = 1'b0;
    send(32'hD0, 32'hD1, 32'hD2, 0, 1, 1'b1, 1'b0);
    send(32'hE0, 32'hE1, 32'hE2, 0, 2, 1'b1, 1'b0);
    in_valid = 1'b1; in_src = {32'hF2, 32'hF1, 32'hF0}; in_sel = 2'd0;
    in_dest = 3'd3; in_wr_en = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid0), 64'd0);
    check("flush_in_ready", 64'(in_ready0), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
    check("flush_nothing_out", 64'(out_valid0), 64'd0);
    check("flush_keeps_sel_err", 64'(sel_err0), 64'd1);

    // Reset mid-stream with S full.
    out_ready = 1'b0;
    send(32'h100, 32'h101, 32'h102, 1, 1, 1'b1, 1'b0);
    send(32'h200, 32'h201, 32'h202, 1, 2, 1'b1, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_dest = 3'd5; in_wr_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    check_reset_values();
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset2", 64'(in_ready0), 64'd1);
    @(posedge clk); #1;

    // Five retired writes: the 2-bit counter wraps to 1.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'(i), 32'(i + 16), 32'(i + 32), i % 3, i + 1, 1'b1, 1'b1);
    end
    idle(3);
    check("retire_wrap_16", 64'(retire_cnt0), 64'd5);
    check("retire_wrap_2",  64'(retire_cnt1), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Parametrised writeback stage for the LC2K pipeline: selects one of NUM_SRC result sources (memory, ALU, PC+1, …), registers the chosen value with its destination register, and presents a register-file write port. It replaces the single-bit, always-enabled writeback mux with a DATA_W-wide datapath, a valid/ready handshake with a 2-entry skid buffer, flush support, a forwarding tap, and a retired-write counter. It sits between the MEM stage and the register file.

## Interface
- DATA_W, 32, width of every source and the written value
- NUM_SRC, 3, number of result sources; index 0 = memResult, 1 = aluResult, 2 = pcPlusOne
- SEL_W, $clog2(NUM_SRC) (min 1), width of in_sel
- REG_AW, 3, register address width (8 LC2K registers)
- ZERO_REG_RO, 0, when 1, writes to register 0 are suppressed
- CNT_W, 16, retired-write counter width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents a writeback record
- in_ready  out  1  stage can accept a record this cycle
- in_src  in  NUM_SRC*DATA_W  packed sources; source k at bits [k*DATA_W +: DATA_W]
- in_sel  in  SEL_W  source select (CONTROL_WRITE_DATA generalised)
- in_dest  in  REG_AW  destination register
- in_wr_en  in  1  record writes the register file (0 for sw/beq/noop/halt)
- flush  in  1  discard all held records
- out_ready  in  1  register file / downstream accepts the head record
- out_valid  out  1  head record valid
- out_we  out  1  register-file write strobe
- out_dest  out  REG_AW  write address
- out_data  out  DATA_W  write value
- fwd_valid  out  1  head record will write a register (equals out_we)
- fwd_dest  out  REG_AW  same as out_dest
- fwd_data  out  DATA_W  same as out_data
- retire_cnt  out  CNT_W  count of records with out_we=1 accepted downstream
- sel_err  out  1  sticky: an accepted record had in_sel >= NUM_SRC

## Operation
- Storage: head register (H) drives outputs; skid register (S) holds one extra record. Each record = {data, dest, wr_en}.
- Selection at capture: data = in_src[in_sel]; if in_sel >= NUM_SRC, data = 0, wr_en forced 0, sel_err set.
- Accept: in_valid && in_ready. Downstream consume: out_valid && out_ready.
- in_ready = !S.valid && !reset (combinational from registered state only; never depends on in_valid).
- Cases per cycle (no flush):
  - H empty: accepted record loads H.
  - H full, consumed, S empty: accepted record loads H; else H empties.
  - H full, consumed, S full: S moves to H, S empties (in_ready was 0).
  - H full, not consumed: accepted record loads S.
- out_we = H.valid && H.wr_en && !(ZERO_REG_RO && H.dest == 0).
- retire_cnt increments by 1 on every consume with out_we=1; wraps modulo 2^CNT_W.
- flush: H and S invalidated next cycle; a record accepted in the flush cycle is dropped; a consume in the flush cycle still counts (the write happens). flush does not clear sel_err or retire_cnt.
- reset: overrides flush and all accepts.

## Timing
- Reset values: out_valid 0, out_we 0, out_dest 0, out_data 0, fwd_* 0, retire_cnt 0, sel_err 0; in_ready 0 during reset cycle, 1 the cycle after.
- Latency: record accepted at edge N appears on out_* after edge N (visible cycle N+1) when H empty or consumed at N.
- Throughput: 1 record/cycle with out_ready held high; in_ready never drops in that case.
- Backpressure: after out_ready deasserts, one more record is absorbed (S), then in_ready = 0 the following cycle; no record is lost or duplicated.
- out_data/out_dest held stable while out_valid && !out_ready.

## Test plan
- Reset then stream 3 records sel=0,1,2 with sources {0x11,0x22,0x33}, dests 1,2,3, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept; retire_cnt=3.
- Hold out_ready=0, drive 3 back-to-back records -> first two accepted, in_ready=0 on third; release out_ready -> records emerge in order, third accepted after S drains.
- ZERO_REG_RO=1, record dest=0 wr_en=1 -> out_valid=1, out_we=0, retire_cnt unchanged; ZERO_REG_RO=0 -> out_we=1.
- NUM_SRC=3, in_sel=3 -> out_data=0, out_we=0, sel_err=1 and stays 1 until reset.
- H and S full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed/incoming records never appear.
- CNT_W=2, retire 5 writes -> retire_cnt=1; reset asserted mid-stream with S full -> all outputs return to reset values next cycle.
